// File: rtl/pc_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pc_ctrl
// Brief    : Fetch program-counter controller with jump/branch redirect FSM.
//            Optional misaligned-redirect trap enabled by macro PC_CTRL_TRAP_EN.
// Revision : 1.0 - initial release
// ============================================================================
module pc_ctrl #(
    parameter int unsigned         PC_WIDTH    = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC    = 32'h0040_0000,
    parameter logic [PC_WIDTH-1:0] TRAP_VECTOR = 32'h0040_0004
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                ENA,
    input  logic                STALL,
    input  logic                JMP_REQ,
    input  logic [PC_WIDTH-1:0] JMP_TARGET,
    input  logic                BR_REQ,
    input  logic [PC_WIDTH-1:0] BR_TARGET,
    input  logic                FETCH_READY,
    output logic                FETCH_VALID,
    output logic [PC_WIDTH-1:0] PC,
    output logic [PC_WIDTH-1:0] PC_NEXT,
    output logic [1:0]          STATE,
    output logic                TRAP
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        HOLD     = 2'd2,
        REDIRECT = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic                w_active;
    logic                w_fire;
    logic                w_redirect;
    logic [PC_WIDTH-1:0] w_tgt_raw;
    logic [PC_WIDTH-1:0] w_redir_pc;

    assign w_active    = ENA && !STALL;
    assign FETCH_VALID = w_active && (state_q == RUN);
    assign w_fire      = FETCH_VALID && FETCH_READY;
    // Redirects are taken from RUN or HOLD independent of FETCH_READY.
    assign w_redirect  = w_active && ((state_q == RUN) || (state_q == HOLD))
                         && (JMP_REQ || BR_REQ);
    assign w_tgt_raw   = JMP_REQ ? JMP_TARGET : BR_TARGET;

`ifdef PC_CTRL_TRAP_EN
    logic w_misaligned;
    logic trap_q;

    assign w_misaligned = |w_tgt_raw[1:0];
    assign w_redir_pc   = w_misaligned ? TRAP_VECTOR : {w_tgt_raw[PC_WIDTH-1:2], 2'b00};
    assign TRAP         = trap_q;
`else
    logic unused_bits;

    assign w_redir_pc  = {w_tgt_raw[PC_WIDTH-1:2], 2'b00};
    assign TRAP        = 1'b0;
    assign unused_bits = ^{TRAP_VECTOR, w_tgt_raw[1:0]};
`endif

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        if (ENA) begin
            case (state_q)
                IDLE: state_d = RUN;
                RUN: begin
                    if (w_redirect) begin
                        state_d = REDIRECT;
                        pc_d    = w_redir_pc;
                    end else begin
                        if (w_fire) pc_d = pc_q + PC_WIDTH'(4);
                        if (STALL) state_d = HOLD;
                    end
                end
                HOLD: begin
                    if (w_redirect) begin
                        state_d = REDIRECT;
                        pc_d    = w_redir_pc;
                    end else if (!STALL) begin
                        state_d = RUN;
                    end
                end
                REDIRECT: state_d = STALL ? HOLD : RUN;
                default:  state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
`ifdef PC_CTRL_TRAP_EN
            trap_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
`ifdef PC_CTRL_TRAP_EN
            trap_q  <= w_redirect && w_misaligned;
`endif
        end
    end

    assign PC      = pc_q;
    assign PC_NEXT = pc_d;
    assign STATE   = state_q;

endmodule
`default_nettype wire

// File: doc/pc_ctrl.md
PC_CTRL -- requirements
Module: pc_ctrl

Interface
REQ-001 The block SHALL provide parameter PC_WIDTH, default 32, width of all PC and target buses.
REQ-002 The block SHALL provide parameter RESET_PC, default 32'h0040_0000, PC value loaded on reset.
REQ-003 The block SHALL provide parameter TRAP_VECTOR, default 32'h0040_0004, used only under the Configuration macro.
REQ-004 The block SHALL provide port CLK, input, 1, single clock, all state updates on rising edge.
REQ-005 The block SHALL provide port RST, input, 1, asynchronous active-high reset.
REQ-006 The block SHALL provide port ENA, input, 1, global advance enable.
REQ-007 The block SHALL provide port STALL, input, 1, pipeline stall request.
REQ-008 The block SHALL provide port JMP_REQ, input, 1, unconditional jump request.
REQ-009 The block SHALL provide port JMP_TARGET, input, PC_WIDTH, jump destination.
REQ-010 The block SHALL provide port BR_REQ, input, 1, taken-branch request.
REQ-011 The block SHALL provide port BR_TARGET, input, PC_WIDTH, branch destination.
REQ-012 The block SHALL provide port FETCH_READY, input, 1, instruction memory accepts the fetch address.
REQ-013 The block SHALL provide port FETCH_VALID, output, 1, PC is a valid fetch address this cycle.
REQ-014 The block SHALL provide port PC, output, PC_WIDTH, registered program counter.
REQ-015 The block SHALL provide port PC_NEXT, output, PC_WIDTH, combinational value PC takes at the next edge.
REQ-016 The block SHALL provide port STATE, output, 2, FSM state for debug: IDLE=0, RUN=1, HOLD=2, REDIRECT=3.
REQ-017 The block SHALL provide port TRAP, output, 1, misaligned-redirect pulse; tied 0 without the macro.

Function
REQ-018 FSM SHALL have states IDLE, RUN, HOLD, REDIRECT; one registered state, one registered PC.
REQ-019 FETCH_VALID SHALL be 1 only in RUN with ENA=1 and STALL=0, combinational from state and inputs.
REQ-020 Fire SHALL be FETCH_VALID and FETCH_READY both 1; on fire with no redirect, PC <= PC+4.
REQ-021 In RUN without fire and without redirect, PC and FETCH_VALID SHALL hold (valid not withdrawn by READY=0).
REQ-022 Redirect priority SHALL be JMP_REQ over BR_REQ over sequential; a redirect is accepted in RUN or HOLD when ENA=1 and STALL=0, regardless of FETCH_READY.
REQ-023 On accepted redirect PC SHALL load the target with bits [1:0] forced to 0, and state SHALL go to REDIRECT.
REQ-024 REDIRECT SHALL last exactly one cycle with FETCH_VALID=0, PC held, JMP_REQ/BR_REQ ignored, then go to RUN (HOLD if STALL=1).
REQ-025 IDLE SHALL go to RUN at the first edge with ENA=1; PC unchanged.
REQ-026 RUN with STALL=1 SHALL go to HOLD; HOLD with STALL=0 SHALL go to RUN; PC held throughout HOLD.
REQ-027 ENA=0 SHALL freeze state and PC and force FETCH_VALID=0 in every state.
REQ-028 PC+4 SHALL wrap modulo 2^PC_WIDTH: 32'hFFFF_FFFC increments to 32'h0000_0000.
REQ-029 PC_NEXT SHALL equal PC whenever no update occurs at the next edge.

Reset
REQ-030 RST=1 SHALL immediately, without a clock edge, force PC=RESET_PC, state=IDLE, FETCH_VALID=0, TRAP=0.
REQ-031 RST asserted mid-REDIRECT or mid-HOLD SHALL discard the pending redirect; after release the first fetch SHALL be RESET_PC.

Configuration
REQ-032 Macro PC_CTRL_TRAP_EN defined: a redirect with target bits [1:0] non-zero SHALL load TRAP_VECTOR instead, assert TRAP for exactly one cycle, and enter REDIRECT.
REQ-033 PC_CTRL_TRAP_EN undefined: low bits SHALL be masked per REQ-023, TRAP constant 0, TRAP_VECTOR unused.

Verification
REQ-034 Reset then ENA=1, READY=1 four cycles -> FETCH_VALID rises one cycle after ENA; PC sequence 0x00400000, 04, 08, 0C.
REQ-035 READY=0 for 3 cycles at PC=0x00400008 -> PC held, FETCH_VALID=1 throughout; READY=1 -> PC=0x0040000C next.
REQ-036 JMP_REQ=1 target 0x00400100 with BR_REQ=1 target 0x00400200 same cycle -> PC=0x00400100, one cycle FETCH_VALID=0, then fetch 0x00400100.
REQ-037 STALL=1 for 2 cycles, with BR_REQ held -> HOLD, PC frozen, branch not taken until STALL=0, then PC=BR_TARGET.
REQ-038 Force PC to 0xFFFFFFFC via jump, fire once -> PC=0x00000000.
REQ-039 RST pulse during REDIRECT, and (with PC_CTRL_TRAP_EN) jump to 0x00400102 -> PC=RESET_PC asynchronously; trap case PC=0x00400004, TRAP high one cycle.
